// File: rtl/decode_issue_ctrl.sv
// Front-end sequencing controller: gates decode/PC advance around loads/stores,
// self-instruction replay, taken-branch flushes and end-of-program halt.
module decode_issue_ctrl #(
    parameter int unsigned FLUSH_CYCLES    = 2,
    parameter int unsigned SELF_SEQ_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT     = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_valid_i,
    input  logic        cu_stall_i,
    input  logic        cu_stall_self_instruct_i,
    input  logic        branch_taken_i,
    input  logic        end_program_i,
    input  logic        mem_ready_i,
    output logic        instr_en_o,
    output logic        pc_en_o,
    output logic        pc_load_o,
    output logic        flush_o,
    output logic        halted_o,
    output logic        mem_timeout_o,
    output logic [2:0]  state_o,
    output logic [15:0] stall_cycles_o
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned STALL_W = 16;

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush
        $error("FLUSH_CYCLES must be in 1..7");
    end
    if (SELF_SEQ_CYCLES < 1 || SELF_SEQ_CYCLES > 7) begin : g_bad_seq
        $error("SELF_SEQ_CYCLES must be in 1..7");
    end
    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
        $error("MEM_TIMEOUT must be in 1..255");
    end

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_SELF_SEQ = 3'd2,
        ST_FLUSH    = 3'd3,
        ST_HALT     = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]   seq_cnt_q, seq_cnt_d;
    logic [CNT_W-1:0]   mem_cnt_q, mem_cnt_d;
    logic               timeout_q, timeout_d;
    logic               halted_q, halted_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic instr_en_c, pc_en_c, pc_load_c, flush_c;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            seq_cnt_q   <= '0;
            mem_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            halted_q    <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            seq_cnt_q   <= seq_cnt_d;
            mem_cnt_q   <= mem_cnt_d;
            timeout_q   <= timeout_d;
            halted_q    <= halted_d;
            stall_q     <= stall_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        seq_cnt_d   = seq_cnt_q;
        mem_cnt_d   = mem_cnt_q;
        timeout_d   = timeout_q;
        instr_en_c  = 1'b0;
        pc_en_c     = 1'b0;
        pc_load_c   = 1'b0;
        flush_c     = 1'b0;

        case (state_q)
            ST_RUN: begin
                instr_en_c = fetch_valid_i & ~branch_taken_i;
                pc_en_c    = instr_en_c;
                pc_load_c  = branch_taken_i;
                if (end_program_i) begin
                    state_d = ST_HALT;
                end else if (branch_taken_i) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = CNT_W'(FLUSH_CYCLES);
                end else if (cu_stall_i && instr_en_c) begin
                    state_d   = ST_MEM_WAIT;
                    mem_cnt_d = '0;
                end else if (cu_stall_self_instruct_i && instr_en_c) begin
                    state_d   = ST_SELF_SEQ;
                    seq_cnt_d = CNT_W'(SELF_SEQ_CYCLES);
                end
            end
            ST_MEM_WAIT: begin
                // Branches cannot resolve while a load/store is outstanding.
                if (mem_ready_i) begin
                    state_d = ST_RUN;
                end else begin
                    mem_cnt_d = mem_cnt_q + CNT_W'(1);
                    if (mem_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = ST_RUN;
                    end
                end
            end
            ST_SELF_SEQ: begin
                instr_en_c = 1'b1;
                seq_cnt_d  = seq_cnt_q - CNT_W'(1);
                if (branch_taken_i) begin
                    pc_load_c   = 1'b1;
                    state_d     = ST_FLUSH;
                    flush_cnt_d = CNT_W'(FLUSH_CYCLES);
                end else if (seq_cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                flush_c     = 1'b1;
                flush_cnt_d = flush_cnt_q - CNT_W'(1);
                if (flush_cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Enables are forced low for the whole reset pulse.
        if (rst_i) begin
            instr_en_c = 1'b0;
            pc_en_c    = 1'b0;
            pc_load_c  = 1'b0;
            flush_c    = 1'b0;
        end

        halted_d = (state_d == ST_HALT);

        stall_d = stall_q;
        if (state_q != ST_HALT && !instr_en_c && stall_q != '1) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    assign instr_en_o     = instr_en_c;
    assign pc_en_o        = pc_en_c;
    assign pc_load_o      = pc_load_c;
    assign flush_o        = flush_c;
    assign halted_o       = halted_q;
    assign mem_timeout_o  = timeout_q;
    assign state_o        = state_q;
    assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: default instance plus a short-timeout
// instance sharing the same stimulus.
module tb_decode_issue_ctrl;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic fetch_valid_i = 1'b0;
    logic cu_stall_i = 1'b0;
    logic cu_stall_self_instruct_i = 1'b0;
    logic branch_taken_i = 1'b0;
    logic end_program_i = 1'b0;
    logic mem_ready_i = 1'b0;

    logic        instr_en_o, pc_en_o, pc_load_o, flush_o, halted_o, mem_timeout_o;
    logic [2:0]  state_o;
    logic [15:0] stall_cycles_o;

    logic        t_instr_en_o, t_pc_en_o, t_pc_load_o, t_flush_o, t_halted_o, t_mem_timeout_o;
    logic [2:0]  t_state_o;
    logic [15:0] t_stall_cycles_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    decode_issue_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .fetch_valid_i(fetch_valid_i),
        .cu_stall_i(cu_stall_i), .cu_stall_self_instruct_i(cu_stall_self_instruct_i),
        .branch_taken_i(branch_taken_i), .end_program_i(end_program_i),
        .mem_ready_i(mem_ready_i), .instr_en_o(instr_en_o), .pc_en_o(pc_en_o),
        .pc_load_o(pc_load_o), .flush_o(flush_o), .halted_o(halted_o),
        .mem_timeout_o(mem_timeout_o), .state_o(state_o), .stall_cycles_o(stall_cycles_o)
    );

    decode_issue_ctrl #(.MEM_TIMEOUT(4)) dut_to (
        .clk_i(clk_i), .rst_i(rst_i), .fetch_valid_i(fetch_valid_i),
        .cu_stall_i(cu_stall_i), .cu_stall_self_instruct_i(cu_stall_self_instruct_i),
        .branch_taken_i(branch_taken_i), .end_program_i(end_program_i),
        .mem_ready_i(mem_ready_i), .instr_en_o(t_instr_en_o), .pc_en_o(t_pc_en_o),
        .pc_load_o(t_pc_load_o), .flush_o(t_flush_o), .halted_o(t_halted_o),
        .mem_timeout_o(t_mem_timeout_o), .state_o(t_state_o), .stall_cycles_o(t_stall_cycles_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        fetch_valid_i = 1'b0; cu_stall_i = 1'b0; cu_stall_self_instruct_i = 1'b0;
        branch_taken_i = 1'b0; end_program_i = 1'b0; mem_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_inputs();
        repeat (2) tick();
        rst_i = 1'b0;
    endtask

    initial begin
        // Reset values, enables forced low while reset is high.
        clear_inputs();
        fetch_valid_i = 1'b1;
        branch_taken_i = 1'b0;
        tick();
        chk("rst_instr_en", 32'(instr_en_o), 0);
        chk("rst_pc_en", 32'(pc_en_o), 0);
        chk("rst_state", 32'(state_o), 0);
        chk("rst_stall", 32'(stall_cycles_o), 0);
        chk("rst_halted", 32'(halted_o), 0);
        chk("rst_timeout", 32'(mem_timeout_o), 0);

        // Load with mem_ready after 3 wait cycles.
        do_reset();
        fetch_valid_i = 1'b1;
        cu_stall_i = 1'b1;
        #1;
        chk("load_issue_en", 32'(instr_en_o), 1);
        chk("load_issue_pc", 32'(pc_en_o), 1);
        tick(); cu_stall_i = 1'b0; #1;
        chk("mw1_state", 32'(state_o), 1);
        chk("mw1_en", 32'(instr_en_o), 0);
        chk("mw1_pc", 32'(pc_en_o), 0);
        tick();
        chk("mw2_en", 32'(instr_en_o), 0);
        tick(); mem_ready_i = 1'b1; #1;
        chk("mw3_en", 32'(instr_en_o), 0);
        tick(); mem_ready_i = 1'b0; #1;
        chk("mw_done_state", 32'(state_o), 0);
        chk("mw_done_en", 32'(instr_en_o), 1);
        chk("mw_done_pc", 32'(pc_en_o), 1);
        chk("mw_stall", 32'(stall_cycles_o), 3);

        // Reset asserted in the middle of a MEM_WAIT.
        cu_stall_i = 1'b1;
        tick(); cu_stall_i = 1'b0; #1;
        chk("mid_mw_state", 32'(state_o), 1);
        rst_i = 1'b1; #1;
        chk("mid_rst_state", 32'(state_o), 0);
        chk("mid_rst_stall", 32'(stall_cycles_o), 0);
        chk("mid_rst_en", 32'(instr_en_o), 0);
        tick(); rst_i = 1'b0; fetch_valid_i = 1'b0; #1;
        chk("post_rst_en_lo", 32'(instr_en_o), 0);
        tick(); fetch_valid_i = 1'b1; #1;
        chk("post_rst_en_hi", 32'(instr_en_o), 1);
        chk("post_rst_stall", 32'(stall_cycles_o), 1);

        // Taken branch from RUN.
        branch_taken_i = 1'b1; #1;
        chk("br_pc_load", 32'(pc_load_o), 1);
        chk("br_en", 32'(instr_en_o), 0);
        chk("br_flush_n", 32'(flush_o), 0);
        tick(); branch_taken_i = 1'b0; #1;
        chk("fl1_state", 32'(state_o), 3);
        chk("fl1_flush", 32'(flush_o), 1);
        chk("fl1_en", 32'(instr_en_o), 0);
        tick();
        chk("fl2_flush", 32'(flush_o), 1);
        tick();
        chk("fl_done_flush", 32'(flush_o), 0);
        chk("fl_done_en", 32'(instr_en_o), 1);

        // Self-instruction replay.
        cu_stall_self_instruct_i = 1'b1;
        tick(); cu_stall_self_instruct_i = 1'b0; #1;
        chk("ss1_state", 32'(state_o), 2);
        chk("ss1_en", 32'(instr_en_o), 1);
        chk("ss1_pc", 32'(pc_en_o), 0);
        tick();
        chk("ss2_en", 32'(instr_en_o), 1);
        chk("ss2_pc", 32'(pc_en_o), 0);
        tick();
        chk("ss_done_state", 32'(state_o), 0);
        chk("ss_done_pc", 32'(pc_en_o), 1);

        // Branch during self-instruction replay.
        cu_stall_self_instruct_i = 1'b1;
        tick(); cu_stall_self_instruct_i = 1'b0; branch_taken_i = 1'b1; #1;
        chk("ssbr_pc_load", 32'(pc_load_o), 1);
        tick(); branch_taken_i = 1'b0; #1;
        chk("ssbr_state", 32'(state_o), 3);
        chk("ssbr_flush", 32'(flush_o), 1);
        repeat (2) tick();
        chk("ssbr_run", 32'(state_o), 0);

        // Load and self-instruction together: load wins.
        cu_stall_i = 1'b1; cu_stall_self_instruct_i = 1'b1;
        tick(); cu_stall_i = 1'b0; cu_stall_self_instruct_i = 1'b0; mem_ready_i = 1'b1; #1;
        chk("both_state", 32'(state_o), 1);
        tick(); mem_ready_i = 1'b0; #1;
        chk("both_run", 32'(state_o), 0);

        // Memory timeout on the MEM_TIMEOUT=4 instance.
        do_reset();
        fetch_valid_i = 1'b1; cu_stall_i = 1'b1;
        tick(); cu_stall_i = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_state", 32'(t_state_o), 1);
            chk("to_wait_flag", 32'(t_mem_timeout_o), 0);
            tick();
        end
        chk("to_run_state", 32'(t_state_o), 0);
        chk("to_flag_set", 32'(t_mem_timeout_o), 1);
        chk("to_ref_state", 32'(state_o), 1);
        mem_ready_i = 1'b1;
        tick(); mem_ready_i = 1'b0; cu_stall_i = 1'b1;
        tick(); cu_stall_i = 1'b0; mem_ready_i = 1'b1; #1;
        chk("to_load2_state", 32'(t_state_o), 1);
        tick(); mem_ready_i = 1'b0; #1;
        chk("to_sticky", 32'(t_mem_timeout_o), 1);
        chk("to_ref_flag", 32'(mem_timeout_o), 0);

        // End of program together with a branch.
        do_reset();
        fetch_valid_i = 1'b1; end_program_i = 1'b1; branch_taken_i = 1'b1; #1;
        chk("halt_pc_load", 32'(pc_load_o), 1);
        chk("halt_en0", 32'(instr_en_o), 0);
        tick(); end_program_i = 1'b0; #1;
        chk("halt_state", 32'(state_o), 4);
        chk("halt_flag", 32'(halted_o), 1);
        chk("halt_pc_load2", 32'(pc_load_o), 0);
        chk("halt_en", 32'(instr_en_o), 0);
        chk("halt_pc_en", 32'(pc_en_o), 0);
        chk("halt_flush", 32'(flush_o), 0);
        repeat (3) tick();
        chk("halt_stay", 32'(state_o), 4);
        chk("halt_stall_frozen", 32'(stall_cycles_o), 1);

        // Stall counter saturation.
        do_reset();
        repeat (65534) tick();
        chk("sat_fffe", 32'(stall_cycles_o), 32'h0000_FFFE);
        repeat (4500) tick();
        chk("sat_ffff", 32'(stall_cycles_o), 32'h0000_FFFF);
        chk("sat_state", 32'(state_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
